// File: rtl/mtm_row_feeder.sv
// mtm_row_feeder: assembles a row-major element stream into NUM_PE x NUM_PE tiles and replays each
// tile as NUM_PE contiguous row beats for mtm_unit. Optional macro: MTM_FEEDER_PINGPONG_EN (two banks).
module mtm_row_feeder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_PE     = 4,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_val,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  row_val,
    output logic [DATA_WIDTH-1:0] row_data [0:NUM_PE-1],
    output logic                  busy
);
`ifdef MTM_FEEDER_PINGPONG_EN
    localparam int unsigned NB = 2;
    localparam logic        PP = 1'b1;
`else
    localparam int unsigned NB = 1;
    localparam logic        PP = 1'b0;
`endif
    localparam int unsigned   CW   = $clog2(NUM_PE);
    localparam int unsigned   GW   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_PE - 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_e;

    logic [DATA_WIDTH-1:0] bank_q [0:NB-1][0:NUM_PE-1][0:NUM_PE-1];
    logic [NB-1:0]         full_q, full_set, full_clr;
    logic [CW-1:0]         wcol_q, wrow_q;
    logic                  wr_sel_q;
    logic                  accept, wr_last;

    state_e                state_q, state_d;
    logic                  row_val_q, row_val_d;
    logic [DATA_WIDTH-1:0] row_data_q [0:NUM_PE-1];
    logic [DATA_WIDTH-1:0] row_data_d [0:NUM_PE-1];
    logic [CW-1:0]         rrow_q, rrow_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  rd_sel_q, rd_sel_d;
    logic                  rd_other, tile_rdy, next_rdy;

    assign in_ready = !full_q[wr_sel_q];
    assign accept   = in_val && in_ready;
    assign wr_last  = accept && (wrow_q == LAST) && (wcol_q == LAST);
    assign rd_other = rd_sel_q ^ PP;

    // A tile completing on this edge counts as ready so row 0 follows its last element directly.
    assign tile_rdy = full_q[rd_sel_q] || (wr_last && (wr_sel_q == rd_sel_q));
    assign next_rdy = PP && (full_q[rd_other] || (wr_last && (wr_sel_q == rd_other)));

    assign row_val  = row_val_q;
    assign row_data = row_data_q;
    assign busy     = (state_q != S_IDLE) || (|full_q);

    always_ff @(posedge clk) begin
        if (accept) bank_q[wr_sel_q][wrow_q][wcol_q] <= in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcol_q   <= '0;
            wrow_q   <= '0;
            wr_sel_q <= 1'b0;
        end else if (accept) begin
            if (wcol_q == LAST) begin
                wcol_q <= '0;
                wrow_q <= (wrow_q == LAST) ? '0 : wrow_q + CW'(1);
            end else begin
                wcol_q <= wcol_q + CW'(1);
            end
            if (wr_last) wr_sel_q <= wr_sel_q ^ PP;
        end
    end

    always_comb begin
        full_set = '0;
        if (wr_last) full_set[wr_sel_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q    <= '0;
            state_q   <= S_IDLE;
            row_val_q <= 1'b0;
            rrow_q    <= '0;
            gap_q     <= '0;
            rd_sel_q  <= 1'b0;
            for (int i = 0; i < NUM_PE; i++) row_data_q[i] <= '0;
        end else begin
            full_q     <= (full_q | full_set) & ~full_clr;
            state_q    <= state_d;
            row_val_q  <= row_val_d;
            rrow_q     <= rrow_d;
            gap_q      <= gap_d;
            rd_sel_q   <= rd_sel_d;
            row_data_q <= row_data_d;
        end
    end

    // Read FSM: rrow_q is the next row to present; wrapping to 0 means the last row is on the bus.
    always_comb begin
        state_d    = state_q;
        row_val_d  = row_val_q;
        row_data_d = row_data_q;
        rrow_d     = rrow_q;
        gap_d      = gap_q;
        rd_sel_d   = rd_sel_q;
        full_clr   = '0;
        case (state_q)
            S_IDLE: begin
                if (tile_rdy) begin
                    state_d    = S_BURST;
                    row_val_d  = 1'b1;
                    row_data_d = bank_q[rd_sel_q][0];
                    rrow_d     = CW'(1);
                end
            end
            S_BURST: begin
                if (rrow_q == '0) begin
                    full_clr[rd_sel_q] = 1'b1;
                    rd_sel_d           = rd_other;
                    if (GAP_CYCLES > 0) begin
                        state_d   = S_GAP;
                        row_val_d = 1'b0;
                        gap_d     = GW'(GAP_CYCLES);
                    end else if (next_rdy) begin
                        row_data_d = bank_q[rd_other][0];
                        rrow_d     = CW'(1);
                    end else begin
                        state_d   = S_IDLE;
                        row_val_d = 1'b0;
                    end
                end else begin
                    row_data_d = bank_q[rd_sel_q][rrow_q];
                    rrow_d     = (rrow_q == LAST) ? '0 : rrow_q + CW'(1);
                end
            end
            S_GAP: begin
                gap_d = gap_q - GW'(1);
                if (gap_q <= GW'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mtm_row_feeder.sv
// tb_mtm_row_feeder: self-checking bench for mtm_row_feeder at default parameters; expectations
// follow MTM_FEEDER_PINGPONG_EN when it is defined for the build.
module tb_mtm_row_feeder;
    localparam int unsigned DW   = 8;
    localparam int unsigned NP   = 4;
    localparam int unsigned GAP  = 4;
    localparam int          MAXC = 256;
`ifdef MTM_FEEDER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic          clk    = 1'b0;
    logic          clk_en = 1'b1;
    logic          rst    = 1'b1;
    logic          in_val = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          row_val;
    logic [DW-1:0] row_data [0:NP-1];
    logic          busy;

    int checks = 0;
    int errors = 0;

    mtm_row_feeder #(.DATA_WIDTH(DW), .NUM_PE(NP), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .in_val(in_val), .in_ready(in_ready), .in_data(in_data),
        .row_val(row_val), .row_data(row_data), .busy(busy)
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Per-cycle observation log and reference timeline (cycle 0 = first cycle after reset release).
    logic          obs_val  [MAXC];
    logic          obs_rdy  [MAXC];
    logic          obs_busy [MAXC];
    logic [DW-1:0] obs_row  [MAXC][NP];
    logic          exp_val  [MAXC];
    logic [DW-1:0] exp_row  [MAXC][NP];
    logic          m_rdy    [MAXC];
    logic [DW-1:0] tile_buf [NP*NP];
    int            ecount;
    int            next_free;
    int            t_from[$], t_to[$], t_bto[$];

    function automatic logic [DW-1:0] elem(input logic [DW-1:0] base, input int k);
        return base + DW'(16 * (k / int'(NP)) + (k % int'(NP)));
    endfunction

    // A tile occupies its bank from the cycle after its last element until its last row is shown.
    function automatic logic model_rdy(input int c);
        int n = 0;
        for (int i = 0; i < t_from.size(); i++)
            if (t_from[i] <= c && c <= t_to[i]) n++;
        return n < NB;
    endfunction

    function automatic logic model_busy(input int c);
        for (int i = 0; i < t_from.size(); i++)
            if (t_from[i] <= c && c <= t_bto[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < MAXC; c++) begin
            exp_val[c] = 1'b0;
            m_rdy[c]   = 1'b1;
            for (int j = 0; j < NP; j++) exp_row[c][j] = '0;
        end
        ecount    = 0;
        next_free = 0;
        t_from.delete();
        t_to.delete();
        t_bto.delete();
    endtask

    // Rows start right after the last element, but not before the previous burst and its gap end.
    task automatic schedule(input int last_c);
        int start = last_c + 1;
        if (start < next_free) start = next_free;
        for (int i = 0; i < NP; i++) begin
            if (start + i < MAXC) begin
                exp_val[start+i] = 1'b1;
                for (int j = 0; j < NP; j++) exp_row[start+i][j] = tile_buf[i*NP+j];
            end
        end
        t_from.push_back(last_c + 1);
        t_to.push_back(start + NP - 1);
        t_bto.push_back(start + NP - 1 + GAP);
        next_free = (GAP > 0) ? start + NP + GAP + 1 : start + NP;
        ecount = 0;
    endtask

    task automatic run_cycle(input int c, input logic v, input logic [DW-1:0] d, output logic acc);
        in_val  = v;
        in_data = d;
        @(negedge clk);
        obs_val[c]  = row_val;
        obs_rdy[c]  = in_ready;
        obs_busy[c] = busy;
        for (int j = 0; j < NP; j++) obs_row[c][j] = row_data[j];
        acc      = v && in_ready;
        m_rdy[c] = model_rdy(c);
        if (v && m_rdy[c]) begin
            tile_buf[ecount] = d;
            ecount++;
            if (ecount == NP * NP) schedule(c);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_val  = 1'b0;
        in_data = '0;
        rst     = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        checks++; if (row_val !== 1'b0) begin errors++; $display("FAIL reset_row_val got %0b exp 0", row_val); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        for (int j = 0; j < NP; j++) begin
            checks++;
            if (row_data[j] !== '0) begin errors++; $display("FAIL reset_row_data[%0d] got %h exp 00", j, row_data[j]); end
        end
        #4 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_after got %0b exp 0", busy); end
    endtask

    task automatic test_async_reset();
        logic acc;
        do_reset();
        for (int c = 0; c < 17; c++) run_cycle(c, c < 16, elem(8'h0A, c), acc);
        @(negedge clk);
        checks++; if (row_val !== 1'b1 || row_data[0] !== 8'h1A) begin
            errors++; $display("FAIL async_pre val %0b row0 %h exp 1 1a", row_val, row_data[0]);
        end
        clk_en = 1'b0;
        #7;
        rst = 1'b0;
        #2;
        checks++; if (row_val !== 1'b0) begin errors++; $display("FAIL async_row_val got %0b exp 0", row_val); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %0b exp 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_in_ready got %0b exp 1", in_ready); end
        for (int j = 0; j < NP; j++) begin
            checks++;
            if (row_data[j] !== '0) begin errors++; $display("FAIL async_row_data[%0d] got %h exp 00", j, row_data[j]); end
        end
        #2 rst = 1'b1;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        logic acc;
        int   n_acc = 0;
        do_reset();
        for (int c = 0; c < 28; c++) begin
            run_cycle(c, c < 16, (c < 16) ? elem(8'h0A, c) : 8'h00, acc);
            if (acc) n_acc++;
        end
        checks++; if (n_acc != 16) begin errors++; $display("FAIL stream_accepts got %0d exp 16", n_acc); end
        for (int c = 0; c < 28; c++) begin
            checks++;
            if (obs_val[c] !== (c >= 16 && c <= 19)) begin
                errors++; $display("FAIL stream_row_val cyc %0d got %0b exp %0b", c, obs_val[c], (c >= 16 && c <= 19));
            end
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (obs_row[16+i][j] !== DW'(8'h0A + 16*i + j)) begin
                    errors++; $display("FAIL stream_row %0d[%0d] got %h exp %h", i, j, obs_row[16+i][j], DW'(8'h0A + 16*i + j));
                end
            end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (obs_row[23][j] !== DW'(8'h3A + j)) begin
                errors++; $display("FAIL stream_hold[%0d] got %h exp %h", j, obs_row[23][j], DW'(8'h3A + j));
            end
        end
        checks++; if (obs_busy[15] !== 1'b0) begin errors++; $display("FAIL stream_busy15 got %0b exp 0", obs_busy[15]); end
        checks++; if (obs_busy[16] !== 1'b1) begin errors++; $display("FAIL stream_busy16 got %0b exp 1", obs_busy[16]); end
        checks++; if (obs_busy[23] !== 1'b1) begin errors++; $display("FAIL stream_busy23 got %0b exp 1", obs_busy[23]); end
        checks++; if (obs_busy[24] !== 1'b0) begin errors++; $display("FAIL stream_busy24 got %0b exp 0", obs_busy[24]); end
    endtask

    task automatic test_toggle();
        logic acc;
        int   n_acc = 0;
        do_reset();
        for (int c = 0; c < 42; c++) begin
            run_cycle(c, (c % 2 == 0) && c <= 30, elem(8'h0A, c / 2), acc);
            if (acc) n_acc++;
        end
        checks++; if (n_acc != 16) begin errors++; $display("FAIL toggle_accepts got %0d exp 16", n_acc); end
        for (int c = 0; c < 42; c++) begin
            checks++;
            if (obs_val[c] !== (c >= 31 && c <= 34)) begin
                errors++; $display("FAIL toggle_row_val cyc %0d got %0b exp %0b", c, obs_val[c], (c >= 31 && c <= 34));
            end
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (obs_row[31+i][j] !== DW'(8'h0A + 16*i + j)) begin
                    errors++; $display("FAIL toggle_row %0d[%0d] got %h exp %h", i, j, obs_row[31+i][j], DW'(8'h0A + 16*i + j));
                end
            end
    endtask

    task automatic test_back_to_back();
        logic acc;
        int   k = 0;
        int   last_acc = -1;
`ifdef MTM_FEEDER_PINGPONG_EN
        int   t2 = 32;
`else
        int   t2 = 36;
`endif
        do_reset();
        for (int c = 0; c < 46; c++) begin
            run_cycle(c, k < 32, elem((k < 16) ? 8'h0A : 8'h4A, k % 16), acc);
            if (acc) begin
                k++;
                last_acc = c;
            end
        end
        checks++; if (last_acc != t2 - 1) begin errors++; $display("FAIL b2b_last_accept got %0d exp %0d", last_acc, t2 - 1); end
        for (int c = 0; c < t2; c++) begin
            logic er = (NB == 2) || !(c >= 16 && c <= 19);
            checks++;
            if (obs_rdy[c] !== er) begin errors++; $display("FAIL b2b_in_ready cyc %0d got %0b exp %0b", c, obs_rdy[c], er); end
        end
        for (int c = 0; c < 46; c++) begin
            logic ev = (c >= 16 && c <= 19) || (c >= t2 && c <= t2 + 3);
            checks++;
            if (obs_val[c] !== ev) begin errors++; $display("FAIL b2b_row_val cyc %0d got %0b exp %0b", c, obs_val[c], ev); end
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (obs_row[t2+i][j] !== DW'(8'h4A + 16*i + j)) begin
                    errors++; $display("FAIL b2b_row2 %0d[%0d] got %h exp %h", i, j, obs_row[t2+i][j], DW'(8'h4A + 16*i + j));
                end
            end
    endtask

    task automatic test_reset_mid();
        logic acc;
        do_reset();
        for (int c = 0; c < 16; c++) run_cycle(c, 1'b1, elem(8'h0A, c), acc);
        in_val = 1'b0;
        @(negedge clk);
        checks++; if (row_val !== 1'b1 || row_data[0] !== 8'h0A) begin
            errors++; $display("FAIL mid_row0 val %0b data %h exp 1 0a", row_val, row_data[0]);
        end
        #1 rst = 1'b0;
        #1;
        checks++; if (row_val !== 1'b0 || busy !== 1'b0 || row_data[0] !== '0) begin
            errors++; $display("FAIL mid_abort val %0b busy %0b data %h exp 0 0 00", row_val, busy, row_data[0]);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        for (int c = 0; c < 28; c++) run_cycle(c, c < 16, DW'(8'hA0 + c), acc);
        for (int c = 0; c < 28; c++) begin
            checks++;
            if (obs_val[c] !== (c >= 16 && c <= 19)) begin
                errors++; $display("FAIL mid_row_val cyc %0d got %0b exp %0b", c, obs_val[c], (c >= 16 && c <= 19));
            end
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (obs_row[16+i][j] !== DW'(8'hA0 + 4*i + j)) begin
                    errors++; $display("FAIL mid_row %0d[%0d] got %h exp %h", i, j, obs_row[16+i][j], DW'(8'hA0 + 4*i + j));
                end
            end
    endtask

    task automatic test_random();
        int            pct [4] = '{30, 60, 90, 100};
        logic          acc;
        logic [DW-1:0] hold [NP];
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int c = 0; c < 170; c++)
                run_cycle(c, (c < 150) && ($urandom_range(99) < pct[r]), DW'($urandom), acc);
            for (int j = 0; j < NP; j++) hold[j] = '0;
            for (int c = 0; c < 170; c++) begin
                logic eb;
                eb = model_busy(c);
                if (exp_val[c]) for (int j = 0; j < NP; j++) hold[j] = exp_row[c][j];
                checks++;
                if (obs_val[c] !== exp_val[c]) begin
                    errors++; $display("FAIL rand%0d_row_val cyc %0d got %0b exp %0b", r, c, obs_val[c], exp_val[c]);
                end
                checks++;
                if (obs_rdy[c] !== m_rdy[c]) begin
                    errors++; $display("FAIL rand%0d_in_ready cyc %0d got %0b exp %0b", r, c, obs_rdy[c], m_rdy[c]);
                end
                checks++;
                if (obs_busy[c] !== eb) begin
                    errors++; $display("FAIL rand%0d_busy cyc %0d got %0b exp %0b", r, c, obs_busy[c], eb);
                end
                for (int j = 0; j < NP; j++) begin
                    checks++;
                    if (obs_row[c][j] !== hold[j]) begin
                        errors++; $display("FAIL rand%0d_row_data cyc %0d [%0d] got %h exp %h", r, c, j, obs_row[c][j], hold[j]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_stream();
        test_toggle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
